// File: rtl/monitor_bus_pkg.sv
// rtl/monitor_bus_pkg.sv - shared FSM encoding, wait width and default monitor memory map
//
// Purpose: definitions used by monitor_bus_arb and monitor_bus_decode.
// Ports  : none (package).
package monitor_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } bus_state_t;

  // Per-slave wait-state field width (0..3 wait cycles).
  localparam int WAIT_W = 2;

  // Slave index width, enough for up to 16 regions.
  localparam int IDX_W = 4;

  localparam int MAP_SLAVES = 6;
  localparam int MAP_ADDR_W = 16;

  // Default monitor map, slave 0 in the low 16 bits:
  // 0 RAM, 1 CPU state, 2 history lo, 3 history hi, 4 ctrl, 5 ROM.
  localparam logic [MAP_SLAVES*MAP_ADDR_W-1:0] MAP_BASE = {
    16'hF800, 16'h9000, 16'h8010, 16'h8000, 16'h7000, 16'h0000
  };
  localparam logic [MAP_SLAVES*MAP_ADDR_W-1:0] MAP_MASK = {
    16'hF800, 16'hF000, 16'hF018, 16'hF010, 16'hF000, 16'hF800
  };

endpackage

// File: rtl/monitor_bus_decode.sv
// rtl/monitor_bus_decode.sv - combinational address-to-slave region decoder
//
// Purpose: compares an address against every region's base/mask pair and
//          reports the lowest-numbered matching region.
// Ports  : address   - CPU address to decode
//          hit_valid - some region matched
//          hit_index - binary index of the lowest matching region
module monitor_bus_decode
  import monitor_bus_pkg::*;
#(
  parameter int NUM_SLAVES = MAP_SLAVES,
  parameter int ADDR_W = MAP_ADDR_W,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = MAP_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = MAP_MASK
) (
  input  logic [ADDR_W-1:0] address,
  output logic              hit_valid,
  output logic [IDX_W-1:0]  hit_index
);

  // Scan from the top down so the lowest matching index is the last written.
  always_comb begin
    hit_valid = 1'b0;
    hit_index = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((address & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        hit_valid = 1'b1;
        hit_index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/monitor_bus_arb.sv
// rtl/monitor_bus_arb.sv - single-master monitor bus with region decode, wait states and error capture
//
// Purpose: accepts one CPU access at a time, strobes the decoded slave in the
//          accept cycle, inserts per-slave wait states and completes with a
//          one-cycle ready pulse. Unmapped accesses complete with bus_error and
//          are counted and logged.
// Ports  : clk, reset_n          - clock, synchronous active-low reset
//          cpu_req/address/write - access request (honoured only when !busy)
//          slave_rdata           - packed per-slave read data
//          slave_wr, slave_rd    - one-hot strobes, accept cycle only
//          read_data             - read result (live in DONE, held otherwise)
//          ready, busy           - completion pulse, access in flight
//          bus_error             - unmapped-access completion pulse
//          err_count             - saturating unmapped-access count
//          err_address           - address of the last unmapped access
module monitor_bus_arb
  import monitor_bus_pkg::*;
#(
  parameter int NUM_SLAVES = 6,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = MAP_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = MAP_MASK,
  parameter logic [NUM_SLAVES*WAIT_W-1:0] SLAVE_WAIT = '0,
  parameter logic [DATA_W-1:0] UNMAPPED_DATA = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cpu_req,
  input  logic [ADDR_W-1:0]            cpu_address,
  input  logic                         cpu_write,
  input  logic [NUM_SLAVES*DATA_W-1:0] slave_rdata,
  output logic [NUM_SLAVES-1:0]        slave_wr,
  output logic [NUM_SLAVES-1:0]        slave_rd,
  output logic [DATA_W-1:0]            read_data,
  output logic                         ready,
  output logic                         busy,
  output logic                         bus_error,
  output logic [7:0]                   err_count,
  output logic [ADDR_W-1:0]            err_address
);

  bus_state_t        state;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_write;
  logic              sel_unmapped;
  logic [ADDR_W-1:0] sel_addr;
  logic [WAIT_W-1:0] wait_cnt;
  logic [DATA_W-1:0] rdata_q;

  logic              hit_valid;
  logic [IDX_W-1:0]  hit_index;
  logic [NUM_SLAVES-1:0] hit_onehot;
  logic [WAIT_W-1:0] hit_wait;
  logic [DATA_W-1:0] sel_rdata;
  logic [DATA_W-1:0] done_rdata;
  logic              accept;

  monitor_bus_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .address   (cpu_address),
    .hit_valid (hit_valid),
    .hit_index (hit_index)
  );

  // Requests arriving while busy are simply dropped; reset also masks them.
  assign accept = reset_n && (state == IDLE) && cpu_req;

  // One-hot of the decoded slave and its wait-state count.
  always_comb begin
    hit_onehot = '0;
    hit_wait   = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (IDX_W'(i) == hit_index) begin
        hit_onehot[i] = hit_valid;
        hit_wait      = SLAVE_WAIT[i*WAIT_W +: WAIT_W];
      end
    end
  end

  // Read data of the slave latched at accept time.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (IDX_W'(i) == sel_idx) begin
        sel_rdata = slave_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign done_rdata = sel_unmapped ? UNMAPPED_DATA : sel_rdata;

  assign slave_wr  = (accept && cpu_write)  ? hit_onehot : '0;
  assign slave_rd  = (accept && !cpu_write) ? hit_onehot : '0;
  assign busy      = reset_n && (state != IDLE);
  assign ready     = reset_n && (state == DONE);
  assign bus_error = ready && sel_unmapped;

  // In DONE a read shows the slave data in the same cycle; otherwise the last
  // registered result is held.
  assign read_data = (ready && !sel_write) ? done_rdata : rdata_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      sel_idx      <= '0;
      sel_write    <= 1'b0;
      sel_unmapped <= 1'b0;
      sel_addr     <= '0;
      wait_cnt     <= '0;
      rdata_q      <= '0;
      err_count    <= '0;
      err_address  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            sel_idx      <= hit_index;
            sel_write    <= cpu_write;
            sel_unmapped <= !hit_valid;
            sel_addr     <= cpu_address;
            wait_cnt     <= hit_wait;
            if (hit_valid && (hit_wait != '0)) begin
              state <= WAIT;
            end else begin
              state <= DONE;
            end
          end
        end
        WAIT: begin
          // wait_cnt is non-zero on entry, so this leaves after exactly W cycles.
          if (wait_cnt == WAIT_W'(1)) begin
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        DONE: begin
          if (!sel_write) begin
            rdata_q <= done_rdata;
          end
          if (sel_unmapped) begin
            err_address <= sel_addr;
            if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_monitor_bus_arb.sv
// tb/tb_monitor_bus_arb.sv - self-checking bench for monitor_bus_arb
module tb_monitor_bus_arb;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        cpu_req;
  logic [15:0] cpu_address;
  logic        cpu_write;
  logic [47:0] slave_rdata;
  logic [5:0]  slave_wr;
  logic [5:0]  slave_rd;
  logic [7:0]  read_data;
  logic        ready;
  logic        busy;
  logic        bus_error;
  logic [7:0]  err_count;
  logic [15:0] err_address;

  logic        cpu_req_b;
  logic [15:0] cpu_address_b;
  logic        cpu_write_b;
  logic [15:0] slave_rdata_b;
  logic [1:0]  slave_wr_b;
  logic [1:0]  slave_rd_b;
  logic [7:0]  read_data_b;
  logic        ready_b;
  logic        busy_b;
  logic        bus_error_b;
  logic [7:0]  err_count_b;
  logic [15:0] err_address_b;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [7:0] last_rd;

  monitor_bus_arb #(
    .NUM_SLAVES (6),
    .ADDR_W     (16),
    .DATA_W     (8),
    .SLAVE_WAIT (12'h300)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_req     (cpu_req),
    .cpu_address (cpu_address),
    .cpu_write   (cpu_write),
    .slave_rdata (slave_rdata),
    .slave_wr    (slave_wr),
    .slave_rd    (slave_rd),
    .read_data   (read_data),
    .ready       (ready),
    .busy        (busy),
    .bus_error   (bus_error),
    .err_count   (err_count),
    .err_address (err_address)
  );

  monitor_bus_arb #(
    .NUM_SLAVES (2),
    .ADDR_W     (16),
    .DATA_W     (8),
    .SLAVE_BASE (32'h0000_0000),
    .SLAVE_MASK (32'hFF00_F000),
    .SLAVE_WAIT (4'h0)
  ) dut_ovl (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_req     (cpu_req_b),
    .cpu_address (cpu_address_b),
    .cpu_write   (cpu_write_b),
    .slave_rdata (slave_rdata_b),
    .slave_wr    (slave_wr_b),
    .slave_rd    (slave_rd_b),
    .read_data   (read_data_b),
    .ready       (ready_b),
    .busy        (busy_b),
    .bus_error   (bus_error_b),
    .err_count   (err_count_b),
    .err_address (err_address_b)
  );

  // One access on the main DUT: accept at the next negedge, then W+1 cycles
  // ending in DONE. exp_slave < 0 means the address is unmapped.
  task automatic do_access(input logic [15:0] addr, input logic wr,
                           input int exp_slave, input int exp_wait, input logic rel_reset);
    exp_t       e;
    exp_t       got;
    logic [5:0] exp_oh;
    @(negedge clk);
    if (rel_reset) reset_n = 1'b1;
    exp_oh = (exp_slave >= 0) ? 6'(1 << exp_slave) : 6'b0;
    e.err  = (exp_slave < 0);
    if (wr)                 e.data = last_rd;
    else if (exp_slave < 0) e.data = 8'h00;
    else                    e.data = slave_rdata[exp_slave*8 +: 8];
    last_rd = e.data;
    sb.push_back(e);
    cpu_req = 1'b1; cpu_address = addr; cpu_write = wr;
    #1;
    n_cmp++;
    if (slave_wr !== (wr ? exp_oh : 6'b0) || slave_rd !== (wr ? 6'b0 : exp_oh)) begin
      n_fail++;
      $display("FAIL accept_strobe addr=%h: got wr=%b rd=%b, required onehot=%b write=%b",
               addr, slave_wr, slave_rd, exp_oh, wr);
    end
    for (int k = 1; k <= exp_wait + 1; k++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b1 || ready !== (k == exp_wait + 1) || slave_wr !== 6'b0 || slave_rd !== 6'b0) begin
        n_fail++;
        $display("FAIL cycle_status addr=%h T+%0d: got busy=%b ready=%b wr=%b rd=%b, required busy=1 ready=%0d no strobe",
                 addr, k, busy, ready, slave_wr, slave_rd, (k == exp_wait + 1));
      end
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty addr=%h: got no expectation, required one", addr);
    end else begin
      got = sb.pop_front();
      if (read_data !== got.data || bus_error !== got.err) begin
        n_fail++;
        $display("FAIL done_result addr=%h: got data=%h err=%b, required data=%h err=%b",
                 addr, read_data, bus_error, got.data, got.err);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cpu_req = 1'b1; cpu_address = 16'h0123; cpu_write = 1'b0;
    cpu_req_b = 1'b0; cpu_address_b = '0; cpu_write_b = 1'b0;
    slave_rdata = 48'h11_22_33_44_55_5A; slave_rdata_b = 16'h3C_C3;
    last_rd = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (slave_wr !== 6'b0 || slave_rd !== 6'b0 || busy !== 1'b0 || ready !== 1'b0 || bus_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wr=%b rd=%b busy=%b ready=%b err=%b, required all 0",
               slave_wr, slave_rd, busy, ready, bus_error);
    end
    n_cmp++;
    if (read_data !== 8'h00 || err_count !== 8'h00 || err_address !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_regs: got rd=%h cnt=%h addr=%h, required 0/0/0", read_data, err_count, err_address);
    end
    @(negedge clk);
    cpu_req = 1'b0; reset_n = 1'b1;
  endtask

  task automatic test_read_w0();
    do_access(16'h0123, 1'b0, 0, 0, 1'b0);
    @(negedge clk); #1;
    n_cmp++;
    if (read_data !== 8'h5A || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL read_hold: got rd=%h busy=%b, required 5a/0", read_data, busy);
    end
  endtask

  task automatic test_write_wait();
    do_access(16'h9000, 1'b1, 4, 3, 1'b0);
    @(negedge clk); #1;
    n_cmp++;
    if (read_data !== 8'h5A || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL write_keeps_data: got rd=%h busy=%b, required 5a/0", read_data, busy);
    end
  endtask

  task automatic test_unmapped();
    do_access(16'hA000, 1'b0, -1, 0, 1'b0);
    @(negedge clk); #1;
    n_cmp++;
    if (err_address !== 16'hA000 || err_count !== 8'd1 || read_data !== 8'h00) begin
      n_fail++;
      $display("FAIL unmapped_log: got addr=%h cnt=%0d rd=%h, required a000/1/00", err_address, err_count, read_data);
    end
    for (int i = 0; i < 299; i++) do_access(16'hA000, 1'b0, -1, 0, 1'b0);
    @(negedge clk); #1;
    n_cmp++;
    if (err_count !== 8'd255) begin
      n_fail++;
      $display("FAIL err_saturate: got cnt=%0d, required 255", err_count);
    end
  endtask

  task automatic test_overlap();
    exp_t e;
    exp_t got;
    @(negedge clk);
    e.err = 1'b0; e.data = slave_rdata_b[7:0];
    sb.push_back(e);
    cpu_req_b = 1'b1; cpu_address_b = 16'h0010; cpu_write_b = 1'b0;
    #1;
    n_cmp++;
    if (slave_rd_b !== 2'b01 || slave_wr_b !== 2'b00) begin
      n_fail++;
      $display("FAIL overlap_strobe: got rd=%b wr=%b, required 01/00", slave_rd_b, slave_wr_b);
    end
    @(negedge clk);
    cpu_req_b = 1'b0;
    #1;
    got = sb.pop_front();
    n_cmp++;
    if (ready_b !== 1'b1 || read_data_b !== got.data || bus_error_b !== got.err) begin
      n_fail++;
      $display("FAIL overlap_done: got ready=%b rd=%h err=%b, required 1/%h/%b",
               ready_b, read_data_b, bus_error_b, got.data, got.err);
    end
  endtask

  task automatic test_back_to_back();
    logic model_idle;
    model_idle = 1'b1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_address = 16'h0123; cpu_write = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_cmp++;
      if (slave_rd !== (model_idle ? 6'b000001 : 6'b0) || ready !== !model_idle) begin
        n_fail++;
        $display("FAIL held_req T+%0d: got rd=%b ready=%b, required accept=%b ready=%b",
                 c, slave_rd, ready, model_idle, !model_idle);
      end
      model_idle = !model_idle;
    end
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b1 || read_data !== 8'h5A || slave_rd !== 6'b0) begin
      n_fail++;
      $display("FAIL held_req_tail: got ready=%b rd=%h strobe=%b, required 1/5a/0", ready, read_data, slave_rd);
    end
    last_rd = 8'h5A;
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    cpu_req = 1'b1; cpu_address = 16'h9000; cpu_write = 1'b1;
    #1;
    n_cmp++;
    if (slave_wr !== 6'b010000) begin
      n_fail++;
      $display("FAIL abort_accept: got wr=%b, required 010000", slave_wr);
    end
    @(negedge clk);
    cpu_req = 1'b0; reset_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_reset: got busy=%b ready=%b, required 0/0", busy, ready);
    end
    last_rd = 8'h00;
    slave_rdata[7:0] = 8'hA7;
    do_access(16'h0123, 1'b0, 0, 0, 1'b1);
    n_cmp++;
    if (err_count !== 8'd0 || err_address !== 16'h0000) begin
      n_fail++;
      $display("FAIL abort_cleared: got cnt=%0d addr=%h, required 0/0000", err_count, err_address);
    end
  endtask

  initial begin
    test_reset();
    test_read_w0();
    test_write_wait();
    test_unmapped();
    test_overlap();
    test_back_to_back();
    test_reset_mid_access();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
